ram_sdp_rr_ctrl_512x32: RTL and testbench



---
 rtl/ram_sdp_ctrl_pkg.sv | 15 +
 rtl/ram_sdp_rr_ctrl_512x32_rr_arb2.sv | 50 +++++
 rtl/ram_sdp_rr_ctrl_512x32.sv | 173 +++++++++++++++++
 tb/tb_ram_sdp_rr_ctrl_512x32.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sdp_ctrl_pkg.sv
// Shared types and constants for the 512x32 SDP RAM controller.
// Holds FSM state encoding, default widths, depth and read latency.
package ram_sdp_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;
    localparam int DEPTH      = 1 << ADDR_W_DEF;
    localparam int RD_LAT     = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ram_sdp_rr_ctrl_512x32_rr_arb2.sv
// Two-way round-robin arbiter with per-request mask and enable.
// Priority flips to the other requester only on an actual grant.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    output logic [1:0] gnt_o
);

    logic       prio_q;
    logic       prio_d;
    logic [1:0] cand;

    // Pick the eligible requester, favouring the one holding priority
    always_comb begin
        cand   = req_i & ~mask_i & {2{en_i}};
        gnt_o  = 2'b00;
        prio_d = prio_q;
        if (!prio_q) begin
            if (cand[0]) begin
                gnt_o = 2'b01;
            end else if (cand[1]) begin
                gnt_o = 2'b10;
            end
        end else begin
            if (cand[1]) begin
                gnt_o = 2'b10;
            end else if (cand[0]) begin
                gnt_o = 2'b01;
            end
        end
        if (gnt_o[0]) begin
            prio_d = 1'b1;
        end else if (gnt_o[1]) begin
            prio_d = 1'b0;
        end
    end

    // Priority pointer; requester 0 first after reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_sdp_rr_ctrl_512x32.sv
// Init/fill and round-robin sharing of a 512x32 simple dual-port RAM.
// Two writers, two readers; reads blocked on same-cycle write address.
module ram_sdp_rr_ctrl_512x32
    import ram_sdp_ctrl_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    output logic              init_done,
    input  logic [1:0]        wr_req,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    output logic [1:0]        wr_gnt,
    input  logic [1:0]        rd_req,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [1:0]        rd_gnt,
    output logic              rd_valid,
    output logic              rd_id,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              arb_en;

    logic [ADDR_W-1:0] wa_sel;
    logic [DATA_W-1:0] wd_sel;
    logic              wr_any;
    logic [1:0]        rd_mask;

    logic              we_q;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] din_d;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] raddr_d;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] id_q;

    // Fill sequencing and return to fill on clear
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arb_en  = 1'b0;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    arb_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State and fill counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    rr_arb2 u_wr_arb (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .en_i   (arb_en),
        .req_i  (wr_req),
        .mask_i (2'b00),
        .gnt_o  (wr_gnt)
    );

    // Granted write and the read-collision mask it implies
    always_comb begin
        wr_any     = |wr_gnt;
        wa_sel     = wr_gnt[1] ? wr_addr1 : wr_addr0;
        wd_sel     = wr_gnt[1] ? wr_data1 : wr_data0;
        rd_mask[0] = wr_any && (rd_addr0 == wa_sel);
        rd_mask[1] = wr_any && (rd_addr1 == wa_sel);
    end

    rr_arb2 u_rd_arb (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .en_i   (arb_en),
        .req_i  (rd_req),
        .mask_i (rd_mask),
        .gnt_o  (rd_gnt)
    );

    // Next RAM port values: fill word in INIT, granted request in RUN
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        din_d   = din_q;
        raddr_d = raddr_q;
        if (state_q == ST_INIT) begin
            we_d    = 1'b1;
            waddr_d = cnt_q;
            din_d   = INIT_VALUE;
        end else if (wr_any) begin
            we_d    = 1'b1;
            waddr_d = wa_sel;
            din_d   = wd_sel;
        end
        if (rd_gnt[1]) begin
            raddr_d = rd_addr1;
        end else if (rd_gnt[0]) begin
            raddr_d = rd_addr0;
        end
    end

    // Registered RAM ports and read-return tracking
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
            raddr_q <= '0;
            vld_q   <= '0;
            id_q    <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            raddr_q <= raddr_d;
            vld_q   <= {vld_q[RD_LAT-2:0], |rd_gnt};
            id_q    <= {id_q[RD_LAT-2:0], rd_gnt[1]};
        end
    end

    assign init_done      = (state_q == ST_RUN);
    assign ram_we         = we_q;
    assign ram_write_addr = waddr_q;
    assign ram_din        = din_q;
    assign ram_read_addr  = raddr_q;
    assign rd_valid       = vld_q[RD_LAT-1];
    assign rd_id          = id_q[RD_LAT-1];
    assign rd_data        = ram_dout;

endmodule

// File: tb/tb_ram_sdp_rr_ctrl_512x32.sv
// Directed bench for ram_sdp_rr_ctrl_512x32 with a behavioural RAM.
// Expected values are hand-derived from the block's timing rules.
module tb_ram_sdp_rr_ctrl_512x32;

    logic        clock;
    logic        reset_n;
    logic        clear;
    logic        init_done;
    logic [1:0]  wr_req;
    logic [8:0]  wr_addr0;
    logic [8:0]  wr_addr1;
    logic [31:0] wr_data0;
    logic [31:0] wr_data1;
    logic [1:0]  wr_gnt;
    logic [1:0]  rd_req;
    logic [8:0]  rd_addr0;
    logic [8:0]  rd_addr1;
    logic [1:0]  rd_gnt;
    logic        rd_valid;
    logic        rd_id;
    logic [31:0] rd_data;
    logic        ram_we;
    logic [8:0]  ram_write_addr;
    logic [31:0] ram_din;
    logic [8:0]  ram_read_addr;
    logic [31:0] ram_dout;

    logic [31:0] mem [512];
    logic        scrub;
    int          n_chk;
    int          n_err;
    int          n_we;
    int          n_init;
    int          bad;
    int          rise;

    ram_sdp_rr_ctrl_512x32 dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .clear          (clear),
        .init_done      (init_done),
        .wr_req         (wr_req),
        .wr_addr0       (wr_addr0),
        .wr_addr1       (wr_addr1),
        .wr_data0       (wr_data0),
        .wr_data1       (wr_data1),
        .wr_gnt         (wr_gnt),
        .rd_req         (rd_req),
        .rd_addr0       (rd_addr0),
        .rd_addr1       (rd_addr1),
        .rd_gnt         (rd_gnt),
        .rd_valid       (rd_valid),
        .rd_id          (rd_id),
        .rd_data        (rd_data),
        .ram_we         (ram_we),
        .ram_write_addr (ram_write_addr),
        .ram_din        (ram_din),
        .ram_read_addr  (ram_read_addr),
        .ram_dout       (ram_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM macro: registered read, read-first on same-address write
    always @(posedge clock) begin
        if (scrub) begin
            for (int i = 0; i < 512; i++) begin
                mem[i] <= 32'hA5A5_0000 | i;
            end
        end else if (ram_we) begin
            mem[ram_write_addr] <= ram_din;
        end
        ram_dout <= mem[ram_read_addr];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk    = 0;
        n_err    = 0;
        scrub    = 1'b1;
        reset_n  = 1'b0;
        clear    = 1'b0;
        wr_req   = 2'b00;
        rd_req   = 2'b00;
        wr_addr0 = '0;
        wr_addr1 = '0;
        wr_data0 = '0;
        wr_data1 = '0;
        rd_addr0 = '0;
        rd_addr1 = '0;
        repeat (3) @(negedge clock);
        check("rst_init_done", init_done, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_gnts", {wr_gnt, rd_gnt}, 0);
        check("rst_rd_valid", {rd_valid, rd_id}, 0);
        check("rst_ports", {ram_write_addr, ram_read_addr}, 0);
        check("rst_din", ram_din, 0);
        scrub   = 1'b0;
        reset_n = 1'b1;

        n_we = 0;
        bad  = 0;
        rise = 0;
        for (int k = 1; k <= 520; k++) begin
            @(negedge clock);
            if (ram_we) begin
                if (ram_write_addr != 9'(n_we) || ram_din != 0) bad++;
                n_we++;
            end
            if (!init_done && (wr_gnt != 0 || rd_gnt != 0)) bad++;
            if (init_done && rise == 0) rise = k + 1;
        end
        check("fill_we_cycles", n_we, 512);
        check("fill_addr_data", bad, 0);
        check("init_done_cycle", rise, 513);

        rd_req   = 2'b01;
        rd_addr0 = 9'd5;
        #1;
        check("rd5_gnt", rd_gnt, 2'b01);
        @(negedge clock);
        rd_req = 2'b00;
        check("rd5_early_valid", rd_valid, 0);
        check("rd5_addr", ram_read_addr, 5);
        @(negedge clock);
        check("rd5_valid", rd_valid, 1);
        check("rd5_id", rd_id, 0);
        check("rd5_data", rd_data, 0);

        @(negedge clock);
        check("rd5_one_shot", rd_valid, 0);
        wr_req   = 2'b11;
        wr_addr0 = 9'd10;
        wr_addr1 = 9'd20;
        wr_data0 = 32'h0000_A010;
        wr_data1 = 32'h0000_B020;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wr_rr_gnt", wr_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) begin
                check("wr_rr_addr", ram_write_addr, (i % 2 == 1) ? 10 : 20);
            end
            @(negedge clock);
        end
        wr_req = 2'b00;
        check("wr_rr_addr_last", ram_write_addr, 20);
        check("wr_rr_din_last", ram_din, 32'h0000_B020);

        wr_req   = 2'b01;
        wr_addr0 = 9'd7;
        wr_data0 = 32'hDEAD_BEEF;
        rd_req   = 2'b10;
        rd_addr1 = 9'd7;
        #1;
        check("col_wgnt", wr_gnt, 2'b01);
        check("col_rgnt_blocked", rd_gnt, 0);
        @(negedge clock);
        wr_req = 2'b00;
        #1;
        check("col_rgnt_retry", rd_gnt, 2'b10);
        @(negedge clock);
        rd_req = 2'b00;
        check("col_early_valid", rd_valid, 0);
        @(negedge clock);
        check("col_valid", rd_valid, 1);
        check("col_id", rd_id, 1);
        check("col_data", rd_data, 32'hDEAD_BEEF);

        @(negedge clock);
        wr_req   = 2'b01;
        wr_addr0 = 9'd7;
        wr_data0 = 32'h1234_5678;
        rd_req   = 2'b11;
        rd_addr0 = 9'd7;
        rd_addr1 = 9'd8;
        #1;
        check("col_alt_gnt", rd_gnt, 2'b10);
        @(negedge clock);
        wr_req = 2'b00;
        rd_req = 2'b01;
        #1;
        check("col_alt_retry", rd_gnt, 2'b01);
        @(negedge clock);
        rd_req = 2'b00;
        check("col_alt_id1", {rd_valid, rd_id}, 2'b11);
        check("col_alt_d1", rd_data, 0);
        @(negedge clock);
        check("col_alt_id0", {rd_valid, rd_id}, 2'b10);
        check("col_alt_d0", rd_data, 32'h1234_5678);

        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            wr_req   = 2'b10;
            wr_addr1 = 9'(i);
            wr_data1 = 32'h1000 + i;
            #1;
            check("wr_lone_gnt", wr_gnt, 2'b10);
        end
        @(negedge clock);
        wr_req = 2'b00;
        @(negedge clock);
        for (int c = 0; c < 7; c++) begin
            check("strm_valid", rd_valid, (c >= 2 && c <= 5) ? 1 : 0);
            if (c >= 2 && c <= 5) begin
                check("strm_data", rd_data, 32'h1000 + c - 2);
                check("strm_id", rd_id, 0);
            end
            if (c < 4) begin
                rd_req   = 2'b01;
                rd_addr0 = 9'(c);
                #1;
                check("strm_gnt", rd_gnt, 2'b01);
            end else begin
                rd_req = 2'b00;
            end
            @(negedge clock);
        end

        rd_req   = 2'b01;
        rd_addr0 = 9'd20;
        #1;
        check("clr_rd_gnt", rd_gnt, 2'b01);
        @(negedge clock);
        rd_req   = 2'b10;
        rd_addr1 = 9'd200;
        wr_req   = 2'b01;
        wr_addr0 = 9'd100;
        wr_data0 = 32'h0000_FFFF;
        clear    = 1'b1;
        #1;
        check("clr_wgnt0", wr_gnt, 0);
        check("clr_rgnt0", rd_gnt, 0);
        @(negedge clock);
        clear = 1'b0;
        check("clr_inflight_valid", rd_valid, 1);
        check("clr_inflight_data", rd_data, 32'h0000_B020);
        n_init = 0;
        bad    = 0;
        while (!init_done && n_init < 600) begin
            if (wr_gnt != 0 || rd_gnt != 0) bad++;
            n_init++;
            @(negedge clock);
        end
        wr_req = 2'b00;
        rd_req = 2'b00;
        check("clr_init_cycles", n_init, 512);
        check("clr_gnt_zero", bad, 0);

        bad = 0;
        for (int c = 0; c < 514; c++) begin
            if (c >= 2 && (!rd_valid || rd_data != 0 || rd_id != 0)) bad++;
            if (c < 512) begin
                rd_req   = 2'b01;
                rd_addr0 = 9'(c);
            end else begin
                rd_req = 2'b00;
            end
            @(negedge clock);
        end
        check("clr_all_init_value", bad, 0);

        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        repeat (100) @(negedge clock);
        check("mid_waddr", ram_write_addr, 99);
        check("mid_init_done", init_done, 0);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_init_done", init_done, 0);
        check("arst_we", ram_we, 0);
        check("arst_ports", {ram_write_addr, ram_read_addr}, 0);
        check("arst_din", ram_din, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("refill_we", ram_we, 1);
        check("refill_addr0", ram_write_addr, 0);
        @(negedge clock);
        check("refill_addr1", ram_write_addr, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
